// File: rtl/iddmm_sched.sv
// iddmm_sched: round-robin job scheduler in front of one shared iddmm
// Montgomery engine. It grants one of R requesters and streams that
// requester's x/y/m words (N words of K bits) into the engine RAMs. It then
// starts the engine and returns the N result words tagged with the requester id.
//
// Optional engine watchdog: define IDDMM_SCHED_TIMEOUT_EN. In that build a job
// that stays in REQ/WAIT for TIMEOUT cycles is aborted with a one-cycle
// res_err pulse. In the default build the scheduler waits for the engine
// indefinitely and res_err is tied low.
module iddmm_sched #(
    parameter int          K       = 256,
    parameter int          N       = 16,
    parameter int          R       = 4,
    parameter int          ADDR_W  = $clog2(N),
    parameter int          RID_W   = (R > 1) ? $clog2(R) : 1,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,

    // requester side
    input  logic [R-1:0]      req_valid,
    output logic [R-1:0]      req_ready,
    input  logic [R*K-1:0]    req_x,
    input  logic [R*K-1:0]    req_y,
    input  logic [R*K-1:0]    req_m,
    input  logic [R*K-1:0]    req_m1,
    output logic [ADDR_W-1:0] ld_addr,

    // engine load / control side
    output logic [2:0]        eng_wr_ena,
    output logic [ADDR_W-1:0] eng_wr_addr,
    output logic [K-1:0]      eng_wr_x,
    output logic [K-1:0]      eng_wr_y,
    output logic [K-1:0]      eng_wr_m,
    output logic [K-1:0]      eng_wr_m1,
    output logic              eng_task_req,
    input  logic              eng_task_grant,
    input  logic              eng_task_end,
    input  logic [K-1:0]      eng_task_res,

    // result side
    output logic              res_valid,
    output logic [K-1:0]      res_data,
    output logic [RID_W-1:0]  res_id,
    output logic              res_last,
    output logic              res_err,
    output logic              busy
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(N - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [RID_W-1:0]  ptr;        // last granted requester
    logic [RID_W-1:0]  gid;        // requester owning the current job
    logic [ADDR_W:0]   wcnt;       // result words received in this job

    logic              any_req;
    logic              sel_found;
    logic [RID_W-1:0]  sel_id;
    logic [RID_W-1:0]  scan_idx;

    logic              start_job;
    logic              load_last;
    logic              grant_hit;
    logic              end_hit;
    logic              end_last;
    logic              timeout_hit;

    assign busy = (state != ST_IDLE);

    // Round-robin pick: first requesting index searching upward from ptr+1 with wrap.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the loop can leave it unassigned and infer a latch.
        any_req   = |req_valid;
        sel_id    = '0;
        sel_found = 1'b0;
        scan_idx  = '0;
        for (int i = 1; i <= R; i++) begin
            scan_idx = RID_W'((int'(ptr) + i) % R);
            if (!sel_found && req_valid[scan_idx]) begin
                sel_id    = scan_idx;
                sel_found = 1'b1;
            end
        end
    end

    // Per-cycle event decode shared by the FSM and the datapath registers.
    always_comb begin
        start_job = (state == ST_IDLE) && any_req;
        load_last = (state == ST_LOAD) && (ld_addr == LAST_ADDR);
        grant_hit = (state == ST_REQ) && eng_task_req && eng_task_grant;
        end_hit   = (state == ST_WAIT) && eng_task_end;
        end_last  = end_hit && (wcnt == LAST_WORD);
    end

    // Next-state logic; a watchdog abort overrides the normal transitions.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_job) state_nxt = ST_LOAD;
            ST_LOAD: if (load_last) state_nxt = ST_REQ;
            ST_REQ:  if (grant_hit) state_nxt = ST_WAIT;
            ST_WAIT: if (end_last)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration registers: round-robin pointer, job owner, acceptance pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= RID_W'(R - 1);
            gid       <= '0;
            req_ready <= '0;
        end else begin
            req_ready <= '0;
            if (start_job) begin
                ptr       <= sel_id;
                gid       <= sel_id;
                req_ready <= R'(1) << sel_id;
            end
        end
    end

    // Operand fetch address: walks 0..N-1 during LOAD, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_addr <= '0;
        end else if (start_job) begin
            ld_addr <= '0;
        end else if (state == ST_LOAD) begin
            ld_addr <= load_last ? '0 : ld_addr + 1'b1;
        end
    end

    // Engine RAM writes lag ld_addr by one cycle; data is the owner's slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_wr_ena  <= '0;
            eng_wr_addr <= '0;
            eng_wr_x    <= '0;
            eng_wr_y    <= '0;
            eng_wr_m    <= '0;
        end else begin
            eng_wr_ena <= (state == ST_LOAD) ? 3'b111 : 3'b000;
            if (state == ST_LOAD) begin
                eng_wr_addr <= ld_addr;
                eng_wr_x    <= req_x[gid*K +: K];
                eng_wr_y    <= req_y[gid*K +: K];
                eng_wr_m    <= req_m[gid*K +: K];
            end
        end
    end

    // Montgomery constant is captured at grant and held for the whole job.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_wr_m1 <= '0;
        end else if (start_job) begin
            eng_wr_m1 <= req_m1[sel_id*K +: K];
        end
    end

    // Start request: raised the cycle after REQ is entered, so the last RAM
    // write is already visible to the engine; dropped once the grant is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_task_req <= 1'b0;
        end else begin
            eng_task_req <= (state == ST_REQ) && !grant_hit && !timeout_hit;
        end
    end

    // Result path: register each engine word with its owner id and count words.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            wcnt      <= '0;
        end else begin
            res_valid <= end_hit;
            res_last  <= end_last;
            if (end_hit) begin
                res_data <= eng_task_res;
            end
            if (end_hit || timeout_hit) begin
                res_id <= gid;
            end
            if ((state == ST_IDLE) || end_last || timeout_hit) begin
                wcnt <= '0;
            end else if (end_hit) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

`ifdef IDDMM_SCHED_TIMEOUT_EN
    logic [31:0] wdog;

    // Abort when the engine has held the job for TIMEOUT cycles; a job that
    // completes on the same cycle is not aborted.
    assign timeout_hit = ((state == ST_REQ) || (state == ST_WAIT)) &&
                         (wdog == 32'(TIMEOUT - 1)) && !end_last;

    // Watchdog counter: cleared on entry to REQ, counts through REQ and WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (load_last) begin
            wdog <= '0;
        end else if ((state == ST_REQ) || (state == ST_WAIT)) begin
            wdog <= wdog + 32'd1;
        end
    end

    // One-cycle abort pulse, aligned with res_id = owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_err <= 1'b0;
        end else begin
            res_err <= timeout_hit;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign res_err        = 1'b0;
    assign unused_timeout = |TIMEOUT;
`endif

endmodule
